// File: rtl/stream_upsizer.sv
// rtl/stream_upsizer.sv - packs Ratio narrow beats into one registered wide word
module stream_upsizer #(
    parameter int DataWidth = 32,
    parameter int Ratio     = 2
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst,
    input  logic [DataWidth-1:0]          data_in,
    input  logic                          last_in,
    input  logic                          vld_in,
    output logic                          ack_in,
    output logic [DataWidth*Ratio-1:0]    data_out,
    output logic [Ratio-1:0]              keep_out,
    output logic                          last_out,
    output logic                          vld_out,
    input  logic                          ack_out,
    output logic                          apdone_blk
);

    localparam int IdxW = $clog2(Ratio);
    localparam int AccW = DataWidth * (Ratio - 1);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(Ratio - 1);

    logic [AccW-1:0]               acc;
    logic [IdxW-1:0]               idx;
    logic                          accept;
    logic                          completing;
    logic                          out_xfer;
    logic [DataWidth*Ratio-1:0]    word_next;
    logic [Ratio-1:0]              keep_next;

    // Ready only depends on the output slot, never on the incoming beat.
    assign ack_in     = ~ap_rst & (~vld_out | ack_out);
    assign apdone_blk = vld_out & ~ack_out;

    assign accept     = vld_in & ack_in;
    assign completing = accept & ((idx == LastIdx) | last_in);
    assign out_xfer   = vld_out & ack_out;

    always_comb begin
        word_next = '0;
        keep_next = '0;
        for (int k = 0; k < Ratio - 1; k++) begin
            if (IdxW'(k) < idx) begin
                word_next[k*DataWidth +: DataWidth] = acc[k*DataWidth +: DataWidth];
                keep_next[k] = 1'b1;
            end
        end
        for (int k = 0; k < Ratio; k++) begin
            if (IdxW'(k) == idx) begin
                word_next[k*DataWidth +: DataWidth] = data_in;
                keep_next[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            acc      <= '0;
            idx      <= '0;
            data_out <= '0;
            keep_out <= '0;
            last_out <= 1'b0;
            vld_out  <= 1'b0;
        end else if (completing) begin
            // A new word may replace one leaving on this same edge: no bubble.
            data_out <= word_next;
            keep_out <= keep_next;
            last_out <= last_in;
            vld_out  <= 1'b1;
            acc      <= '0;
            idx      <= '0;
        end else begin
            if (out_xfer) begin
                data_out <= '0;
                keep_out <= '0;
                last_out <= 1'b0;
                vld_out  <= 1'b0;
            end
            if (accept) begin
                for (int k = 0; k < Ratio - 1; k++) begin
                    if (IdxW'(k) == idx) begin
                        acc[k*DataWidth +: DataWidth] <= data_in;
                    end
                end
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stream_upsizer.sv
// tb/tb_stream_upsizer.sv - table plus scoreboard bench for stream_upsizer at Ratio 2 and 4
module tb_stream_upsizer;

    typedef struct {
        logic [127:0] data;
        logic [3:0]   keep;
        logic         last;
    } word_t;

    typedef struct {
        int           unit;
        logic [31:0]  d;
        logic         l;
        logic         done;
        logic [127:0] wd;
        logic [3:0]   wk;
    } vec_t;

    logic         clk;
    logic         rst;
    logic [31:0]  din  [2];
    logic         lin  [2];
    logic         vin  [2];
    logic         ain  [2];
    logic         lout [2];
    logic         vout [2];
    logic         aout [2];
    logic         blk  [2];
    logic [63:0]  dout_a;
    logic [127:0] dout_b;
    logic [1:0]   keep_a;
    logic [3:0]   keep_b;

    word_t exp_q0[$];
    word_t exp_q1[$];
    vec_t  tbl[$];

    int n_tests = 0;
    int n_fail  = 0;
    int waits   = 0;

    stream_upsizer #(.DataWidth(32), .Ratio(2)) dut_a (
        .ap_clk(clk), .ap_rst(rst),
        .data_in(din[0]), .last_in(lin[0]), .vld_in(vin[0]), .ack_in(ain[0]),
        .data_out(dout_a), .keep_out(keep_a), .last_out(lout[0]), .vld_out(vout[0]),
        .ack_out(aout[0]), .apdone_blk(blk[0])
    );

    stream_upsizer #(.DataWidth(32), .Ratio(4)) dut_b (
        .ap_clk(clk), .ap_rst(rst),
        .data_in(din[1]), .last_in(lin[1]), .vld_in(vin[1]), .ack_in(ain[1]),
        .data_out(dout_b), .keep_out(keep_b), .last_out(lout[1]), .vld_out(vout[1]),
        .ack_out(aout[1]), .apdone_blk(blk[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic word_t mk(logic [127:0] d, logic [3:0] k, logic l);
        word_t w;
        w.data = d;
        w.keep = k;
        w.last = l;
        return w;
    endfunction

    function automatic vec_t v(int u, logic [31:0] d, logic l, logic done,
                               logic [127:0] wd, logic [3:0] wk);
        vec_t r;
        r.unit = u; r.d = d; r.l = l; r.done = done; r.wd = wd; r.wk = wk;
        return r;
    endfunction

    always @(negedge clk) begin
        word_t w;
        if (!rst) begin
            if (vout[0] && aout[0]) begin
                if (exp_q0.size() == 0) begin
                    chk("a_unexpected_word", 128'(dout_a), 128'hx);
                end else begin
                    w = exp_q0.pop_front();
                    chk("a_data", 128'(dout_a), w.data);
                    chk("a_keep", 128'(keep_a), 128'(w.keep));
                    chk("a_last", 128'(lout[0]), 128'(w.last));
                end
            end
            if (vout[1] && aout[1]) begin
                if (exp_q1.size() == 0) begin
                    chk("b_unexpected_word", dout_b, 128'hx);
                end else begin
                    w = exp_q1.pop_front();
                    chk("b_data", dout_b, w.data);
                    chk("b_keep", 128'(keep_b), 128'(w.keep));
                    chk("b_last", 128'(lout[1]), 128'(w.last));
                end
            end
        end
    end

    task automatic send(input int u, input logic [31:0] d, input logic l);
        int n = 0;
        din[u] = d;
        lin[u] = l;
        vin[u] = 1'b1;
        @(negedge clk);
        while (!ain[u] && n < 50) begin
            @(negedge clk);
            n++;
        end
        waits += n;
        if (!ain[u]) chk("ack_in_timeout", 128'(ain[u]), 128'd1);
        @(posedge clk);
        #1;
        vin[u] = 1'b0;
        lin[u] = 1'b0;
    endtask

    task automatic expect_word(input int u, input logic [127:0] d, input logic [3:0] k, input logic l);
        if (u == 0) exp_q0.push_back(mk(d, k, l));
        else        exp_q1.push_back(mk(d, k, l));
    endtask

    initial begin
        int n;
        tbl.push_back(v(0, 32'h11, 1'b0, 1'b0, 128'h0, 4'h0));
        tbl.push_back(v(0, 32'h22, 1'b0, 1'b1, 128'h00000022_00000011, 4'h3));
        tbl.push_back(v(0, 32'h33, 1'b0, 1'b0, 128'h0, 4'h0));
        tbl.push_back(v(0, 32'h44, 1'b0, 1'b1, 128'h00000044_00000033, 4'h3));
        tbl.push_back(v(0, 32'h5,  1'b1, 1'b1, 128'h00000000_00000005, 4'h1));
        tbl.push_back(v(0, 32'h66, 1'b0, 1'b0, 128'h0, 4'h0));
        tbl.push_back(v(0, 32'h77, 1'b1, 1'b1, 128'h00000077_00000066, 4'h3));
        tbl.push_back(v(1, 32'hA,  1'b0, 1'b0, 128'h0, 4'h0));
        tbl.push_back(v(1, 32'hB,  1'b1, 1'b1, 128'h0000000B_0000000A, 4'h3));
        tbl.push_back(v(1, 32'hC,  1'b0, 1'b0, 128'h0, 4'h0));
        tbl.push_back(v(1, 32'hD,  1'b0, 1'b0, 128'h0, 4'h0));
        tbl.push_back(v(1, 32'hE,  1'b0, 1'b0, 128'h0, 4'h0));
        tbl.push_back(v(1, 32'hF,  1'b0, 1'b1, 128'h0000000F_0000000E_0000000D_0000000C, 4'hF));
        tbl.push_back(v(1, 32'h1,  1'b1, 1'b1, 128'h00000001, 4'h1));
        tbl.push_back(v(1, 32'h2,  1'b0, 1'b0, 128'h0, 4'h0));
        tbl.push_back(v(1, 32'h3,  1'b0, 1'b0, 128'h0, 4'h0));
        tbl.push_back(v(1, 32'h4,  1'b1, 1'b1, 128'h00000004_00000003_00000002, 4'h7));

        rst = 1'b0;
        for (int u = 0; u < 2; u++) begin
            din[u] = '0; lin[u] = 1'b0; vin[u] = 1'b0; aout[u] = 1'b1;
        end
        #1 rst = 1'b1;
        #2;
        chk("rst_a_vld",  128'(vout[0]), 128'd0);
        chk("rst_a_ack",  128'(ain[0]),  128'd0);
        chk("rst_a_blk",  128'(blk[0]),  128'd0);
        chk("rst_a_data", 128'(dout_a),  128'd0);
        chk("rst_b_vld",  128'(vout[1]), 128'd0);
        chk("rst_b_ack",  128'(ain[1]),  128'd0);
        chk("rst_b_keep", 128'(keep_b),  128'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            if (tbl[i].done) expect_word(tbl[i].unit, tbl[i].wd, tbl[i].wk, tbl[i].l);
            send(tbl[i].unit, tbl[i].d, tbl[i].l);
        end
        chk("ack_in_never_low", 128'(waits), 128'd0);

        // Stall with a completing beat waiting; release must swap words with no bubble.
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        send(0, 32'h100, 1'b0);
        aout[0] = 1'b0;
        expect_word(0, 128'h00000200_00000100, 4'h3, 1'b0);
        send(0, 32'h200, 1'b0);
        expect_word(0, 128'h00000000_00000300, 4'h1, 1'b1);
        din[0] = 32'h300; lin[0] = 1'b1; vin[0] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_data", 128'(dout_a), 128'h00000200_00000100);
            chk("stall_ack_in", 128'(ain[0]), 128'd0);
            chk("stall_blk", 128'(blk[0]), 128'd1);
        end
        @(posedge clk); #1;
        aout[0] = 1'b1;
        @(negedge clk);
        chk("release_ack_in", 128'(ain[0]), 128'd1);
        @(posedge clk); #1;
        vin[0] = 1'b0; lin[0] = 1'b0;
        @(negedge clk);
        chk("no_bubble_vld", 128'(vout[0]), 128'd1);
        @(posedge clk); #1;

        // Async reset with a partial word in unit b and a stalled word in unit a.
        send(1, 32'h1, 1'b0);
        send(1, 32'h2, 1'b0);
        aout[0] = 1'b0;
        send(0, 32'h7, 1'b0);
        send(0, 32'h8, 1'b0);
        #2 rst = 1'b1;
        #1;
        exp_q0.delete();
        chk("async_a_vld",  128'(vout[0]), 128'd0);
        chk("async_a_data", 128'(dout_a),  128'd0);
        chk("async_a_blk",  128'(blk[0]),  128'd0);
        chk("async_a_ack",  128'(ain[0]),  128'd0);
        chk("async_b_vld",  128'(vout[1]), 128'd0);
        chk("async_b_data", dout_b,        128'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        aout[0] = 1'b1;
        @(posedge clk); #1;
        send(1, 32'h1, 1'b0);
        send(1, 32'h2, 1'b0);
        send(1, 32'h3, 1'b0);
        expect_word(1, 128'h00000004_00000003_00000002_00000001, 4'hF, 1'b0);
        send(1, 32'h4, 1'b0);
        send(0, 32'h9, 1'b0);
        expect_word(0, 128'h0000000A_00000009, 4'h3, 1'b0);
        send(0, 32'hA, 1'b0);

        n = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain_q0", 128'(exp_q0.size()), 128'd0);
        chk("drain_q1", 128'(exp_q1.size()), 128'd0);
        chk("idle_a_vld", 128'(vout[0]), 128'd0);
        chk("idle_b_vld", 128'(vout[1]), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_upsizer.md
# stream_upsizer

Stream width upsizer placed directly downstream of a register slice in the RM communication path. It consumes narrow `DataWidth`-bit beats over a valid/ack handshake and packs `Ratio` consecutive beats into one wide word. A `last_in` marker flushes a partial word early. Output is registered with a valid/ack handshake, and one narrow beat per cycle is sustained when the consumer keeps `ack_out` high.

## Interface
Parameters:
- `DataWidth`, default 32: narrow beat width in bits.
- `Ratio`, default 2: beats packed per wide word. Legal range 2..8.

Ports:
- `ap_clk`  in  1: single clock; all state updates on the rising edge.
- `ap_rst`  in  1: reset, asynchronous, active-high.
- `data_in`  in  DataWidth: narrow beat.
- `last_in`  in  1: marks the final beat of a packet; qualified by `vld_in`.
- `vld_in`  in  1: input beat valid.
- `ack_in`  out  1: input ready. A beat transfers on a rising edge where `vld_in & ack_in`.
- `data_out`  out  DataWidth*Ratio: packed word. Lane k occupies bits [k*DataWidth +: DataWidth].
- `keep_out`  out  Ratio: bit k set means lane k holds a real beat.
- `last_out`  out  1: this word ends a packet.
- `vld_out`  out  1: output word valid.
- `ack_out`  in  1: downstream ready. A word transfers on a rising edge where `vld_out & ack_out`.
- `apdone_blk`  out  1: `vld_out & ~ack_out`. High when the output is stalled holding data.

## Operation
Internal state:
- `acc`: Ratio-1 lane registers for lanes 0..Ratio-2.
- `idx`: lane index, 0..Ratio-1.
- Output register: `data_out`, `keep_out`, `last_out`, `vld_out`.

Handshake:
- `ack_in = ~ap_rst & (~vld_out | ack_out)`.
- `ack_in` is combinational in `ack_out` only. It never depends on `vld_in`, `last_in` or `data_in`.

Accepted beat, non-completing (`idx < Ratio-1` and `last_in = 0`):
- `data_in` is written to `acc` lane `idx`.
- `idx` increments by 1.
- Output register is unchanged, except that it clears if its word transfers on the same edge.

Accepted beat, completing (`idx == Ratio-1` or `last_in = 1`):
- Output register loads `data_out` = `acc` lanes 0..idx-1, `data_in` in lane `idx`, zeros above `idx`.
- `keep_out` loads bits 0..idx set and all others clear.
- `last_out` loads `last_in`; `vld_out` loads 1.
- `idx` returns to 0 and `acc` clears to 0.

Output transfer with no completing beat on the same edge:
- `vld_out` clears to 0.
- `data_out`, `keep_out` and `last_out` clear to 0.

Simultaneous output transfer and completing input beat:
- The new word loads and `vld_out` stays 1. No bubble is inserted.

Stall:
- While `vld_out & ~ack_out`, all output signals are held stable and `ack_in` is 0.
- `acc` and `idx` are frozen.

Packet boundary:
- A word never spans packets. `last_in` on any lane closes the word.
- `last_in` at `idx == Ratio-1` gives a full word with `last_out = 1`.

Reset (asynchronous, any time including mid-word):
- `vld_out`, `data_out`, `keep_out`, `last_out`, `idx` and `acc` clear to 0 immediately.
- `ack_in` and `apdone_blk` go to 0.
- A partially packed word is discarded.
- Operation resumes on the first rising edge after `ap_rst` deasserts.

## Timing
- Latency: the completing beat is accepted on edge N, and `vld_out` is 1 from edge N until the word transfers.
- Throughput: one narrow beat per cycle while `ack_out` is held high. One wide word every `Ratio` cycles.
- Combinational paths: `ack_out` to `ack_in`, and `ack_out` to `apdone_blk`. All other outputs are registered.
- Reset values: `ack_in` = 0, `data_out` = 0, `keep_out` = 0, `last_out` = 0, `vld_out` = 0, `apdone_blk` = 0.

## Test plan
- Ratio=2, DataWidth=32, `ack_out` = 1. Stream 0x11, 0x22, 0x33, 0x44 with no `last_in`. Required: words 0x00000022_00000011 then 0x00000044_00000033, each with `keep_out` = 2'b11 and `last_out` = 0. `ack_in` stays 1 throughout.
- Ratio=4. Send 0xA, then 0xB with `last_in` = 1. Required: `data_out` lanes = {0, 0, 0xB, 0xA}, `keep_out` = 4'b0011, `last_out` = 1. The next beat lands in lane 0.
- Ratio=2. Send a single beat 0x5 with `last_in` = 1 at `idx` = 0. Required: `keep_out` = 2'b01, lane 1 = 0, `last_out` = 1.
- Ratio=2. Hold `ack_out` = 0 for 5 cycles after the first word forms. Required: `data_out` stable, `ack_in` = 0, `apdone_blk` = 1. On `ack_out` rising, a pending completing beat loads the next word on the same edge with no bubble.
- Ratio=4. Accept 2 beats, then pulse `ap_rst` asynchronously mid-cycle. Required: all outputs 0 immediately. After release, beats 0x1 through 0x4 produce one word with `keep_out` = 4'hF and no residue from before reset.
